flex_in_capture: RTL

FLEX_IN_CAPTURE -- requirements
Module: flex_in_capture

---
 rtl/flex_pkg.sv | 36 +++
 rtl/flex_sync.sv | 38 +++
 rtl/flex_in_capture.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/flex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flex_pkg
//  Description : Shared definitions for the flex input-capture block:
//                default bus widths, register-group offsets, bus FSM state
//                encoding and address-decode helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package flex_pkg;

    localparam int c_BB_ADDR_BUS_WIDTH = 16;
    localparam int c_BB_DATA_BUS_WIDTH = 16;

    // Register groups; offset = group * Pn + word index
    localparam logic [1:0] c_GRP_LIVE  = 2'd0;  // synchronized live value, RO
    localparam logic [1:0] c_GRP_LATCH = 2'd1;  // edge latch, write-1-to-clear
    localparam logic [1:0] c_GRP_RISE  = 2'd2;  // rising-edge enable mask, RW
    localparam logic [1:0] c_GRP_FALL  = 2'd3;  // falling-edge enable mask, RW

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } bus_state_t;

    // Words per group, rounded up to a power of two
    function automatic int flex_pn(input int n);
        return 1 << $clog2(n);
    endfunction

    // Number of low address bits consumed by the register window
    function automatic int flex_sel(input int n);
        return $clog2(flex_pn(n)) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flex_sync.sv
`default_nettype none
// ============================================================================
//  Module      : flex_sync
//  Description : Multi-stage flip-flop synchronizer for a vector of
//                asynchronous inputs.
//  Ports       : clock  - rising-edge clock
//                nreset - asynchronous active-low reset (clears all stages)
//                i_d    - asynchronous input vector
//                o_q    - synchronized output (last stage)
//  Revision    : 1.0 - initial release
// ============================================================================
module flex_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int s = 1; s < STAGES; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/flex_in_capture.sv
`default_nettype none
// ============================================================================
//  Module      : flex_in_capture
//  Description : Bus-mapped capture of N asynchronous input words with
//                per-bit rise/fall edge detection, sticky edge latches and an
//                interrupt that is the OR of all latched edges.
//  Ports       : clock, nreset          - clock, async active-low reset
//                addr, addr_strobe      - bus address and its qualifier
//                read_trg, write_trg    - bus cycle triggers
//                data_w                 - write data
//                data_r, data_r_act     - read data and read-data valid
//                dtack                  - cycle acknowledge
//                bits                   - asynchronous inputs, N words
//                irq                    - registered OR of all edge latches
//  Revision    : 1.0 - initial release
// ============================================================================
module flex_in_capture
    import flex_pkg::*;
#(
    parameter int          addr_bus_width = c_BB_ADDR_BUS_WIDTH,
    parameter int          data_bus_width = c_BB_DATA_BUS_WIDTH,
    parameter int unsigned base_addr      = 0,
    parameter int          nr_registers   = 1,
    parameter int          sync_stages    = 2
) (
    input  logic                                   clock,
    input  logic                                   nreset,
    input  logic [addr_bus_width-1:0]              addr,
    input  logic                                   addr_strobe,
    input  logic                                   read_trg,
    input  logic                                   write_trg,
    input  logic [data_bus_width-1:0]              data_w,
    output logic [data_bus_width-1:0]              data_r,
    output logic                                   data_r_act,
    output logic                                   dtack,
    input  logic [nr_registers*data_bus_width-1:0] bits,
    output logic                                   irq
);

    localparam int c_W   = data_bus_width;
    localparam int c_N   = nr_registers;
    localparam int c_NW  = c_N * c_W;
    localparam int c_PN  = flex_pn(c_N);
    localparam int c_SEL = flex_sel(c_N);
    localparam int c_KW  = 7;
    localparam logic [addr_bus_width-1:0] c_BASE  = addr_bus_width'(base_addr);
    localparam logic [c_SEL-1:0]          c_KMASK = c_SEL'(c_PN - 1);

    // ---------------- synchronizer, previous value, edge detect -------------
    logic [c_NW-1:0] w_sync;
    logic [c_NW-1:0] r_prev;
    logic [c_NW-1:0] r_latch;
    logic [c_NW-1:0] r_rise_mask;
    logic [c_NW-1:0] r_fall_mask;
    logic [c_NW-1:0] w_rise;
    logic [c_NW-1:0] w_fall;
    logic [c_NW-1:0] w_clr;
    logic            r_irq;

    flex_sync #(
        .WIDTH  (c_NW),
        .STAGES (sync_stages)
    ) u_sync (
        .clock  (clock),
        .nreset (nreset),
        .i_d    (bits),
        .o_q    (w_sync)
    );

    assign w_rise = w_sync & ~r_prev & r_rise_mask;
    assign w_fall = ~w_sync & r_prev & r_fall_mask;

    // ---------------- address decode ----------------------------------------
    logic             w_selected;
    logic [c_SEL-1:0] w_offset;
    logic [1:0]       w_group;
    logic [c_KW-1:0]  w_k;
    logic             w_k_ok;

    assign w_selected = addr_strobe &
                        (addr[addr_bus_width-1:c_SEL] == c_BASE[addr_bus_width-1:c_SEL]);
    assign w_offset   = addr[c_SEL-1:0];
    assign w_group    = w_offset[c_SEL-1 -: 2];
    assign w_k        = c_KW'(w_offset & c_KMASK);
    assign w_k_ok     = (w_k < c_KW'(c_N));

    // ---------------- bus FSM -----------------------------------------------
    bus_state_t r_state;
    bus_state_t w_state_nxt;
    logic       w_start;
    logic       w_end;
    logic       w_rd_act;
    logic       w_wr_act;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Only the IDLE->WAIT transition performs an action, so a held trigger
    // never repeats a write or W1C.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_selected && (read_trg || write_trg) && w_k_ok) begin
                    w_state_nxt = ST_WAIT;
                    w_start     = 1'b1;
                end
            end
            ST_WAIT: begin
                if ((!read_trg && !write_trg) || !w_selected) begin
                    w_state_nxt = ST_IDLE;
                    w_end       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A cycle with both triggers raised is treated as a read
    assign w_rd_act = w_start & read_trg;
    assign w_wr_act = w_start & ~read_trg;

    // ---------------- read mux and W1C clear vector -------------------------
    logic [c_W-1:0] w_rd_word;

    always_comb begin
        w_rd_word = '0;
        w_clr     = '0;
        for (int i = 0; i < c_N; i++) begin
            if (w_k == c_KW'(i)) begin
                case (w_group)
                    c_GRP_LIVE:  w_rd_word = w_sync[i*c_W +: c_W];
                    c_GRP_LATCH: w_rd_word = r_latch[i*c_W +: c_W];
                    c_GRP_RISE:  w_rd_word = r_rise_mask[i*c_W +: c_W];
                    default:     w_rd_word = r_fall_mask[i*c_W +: c_W];
                endcase
                if (w_wr_act && (w_group == c_GRP_LATCH)) begin
                    w_clr[i*c_W +: c_W] = data_w;
                end
            end
        end
    end

    // ---------------- capture state -----------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_prev      <= '0;
            r_latch     <= '0;
            r_rise_mask <= '0;
            r_fall_mask <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_prev  <= w_sync;
            // New edges are ORed in after the clear so a coincident set wins
            r_latch <= (r_latch & ~w_clr) | w_rise | w_fall;
            r_irq   <= |r_latch;
            for (int i = 0; i < c_N; i++) begin
                if (w_wr_act && (w_k == c_KW'(i))) begin
                    if (w_group == c_GRP_RISE) begin
                        r_rise_mask[i*c_W +: c_W] <= data_w;
                    end
                    if (w_group == c_GRP_FALL) begin
                        r_fall_mask[i*c_W +: c_W] <= data_w;
                    end
                end
            end
        end
    end

    // ---------------- bus response ------------------------------------------
    logic [c_W-1:0] r_data_r;
    logic           r_data_r_act;
    logic           r_dtack;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_data_r     <= '0;
            r_data_r_act <= 1'b0;
            r_dtack      <= 1'b0;
        end else if (w_start) begin
            r_dtack      <= 1'b1;
            r_data_r_act <= w_rd_act;
            if (w_rd_act) begin
                r_data_r <= w_rd_word;
            end
        end else if (w_end) begin
            r_dtack      <= 1'b0;
            r_data_r_act <= 1'b0;
        end
    end

    assign data_r     = r_data_r;
    assign data_r_act = r_data_r_act;
    assign dtack      = r_dtack;
    assign irq        = r_irq;

endmodule
`default_nettype wire
